// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants for the fetch front end: FSM encoding, reset PC default
// and the opcode values also used by control_unit.
package instr_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter: load (word aligned) has priority over sequential increment.
module instr_fetch_unit_pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] target_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & WORD_MASK;
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(PC_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch sequencer feeding decode, with
// branch/jump redirect and squash of in-flight or held instructions.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [6:0]      instr_opcode,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [31:0]     fetch_count,
  output logic [1:0]      dbg_state
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [1:0]      state_q, state_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            pc_load, pc_inc;
  logic [XLEN-1:0] pc;

  instr_fetch_unit_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (pc_load),
    .target_i (redirect_target),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  // Decode handshake: a word transfers on a cycle with instr_valid && instr_ready
  // and no redirect_valid; instr/instr_pc stay stable while valid is held.
  always_comb begin
    state_d       = state_q;
    discard_d     = discard_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    fetch_count_d = fetch_count_q;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;
    case (state_q)
      S_BOOT: begin
        pc_load = redirect_valid;
        state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
        if (redirect_valid) begin
          pc_load   = 1'b1;
          discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (discard_q || redirect_valid) begin
            pc_load   = redirect_valid;
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc;
            state_d    = S_HOLD;
          end
        end else if (redirect_valid) begin
          // Response still owed for the old PC; remember to drop it.
          pc_load   = 1'b1;
          discard_d = 1'b1;
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          state_d = S_REQ;
        end else if (instr_ready) begin
          pc_inc        = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = S_REQ;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_BOOT;
      discard_q     <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_req     = (state_q == S_REQ);
  assign imem_addr    = pc & WORD_MASK;
  assign instr_valid  = (state_q == S_HOLD);
  assign instr        = instr_q;
  assign instr_opcode = instr_q[6:0];
  assign instr_pc     = instr_pc_q;
  assign fetch_count  = fetch_count_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scoreboard of expected fetch addresses and
// accepted instructions, plus a second instance built with a top-of-memory reset PC.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_rvalid, instr_valid, instr_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_target, fetch_count;
  logic [6:0]  instr_opcode;
  logic [1:0]  dbg_state;

  logic        rst_w_n;
  logic        w_req, w_rvalid, w_valid, w_ready, w_redir;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_target, w_count;
  logic [6:0]  w_opcode;
  logic [1:0]  w_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 1;
  logic [31:0] mem_a;
  logic [63:0] mon_e;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_instr_q[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_opcode(instr_opcode), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .fetch_count(fetch_count), .dbg_state(dbg_state)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_w_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(w_ready),
    .instr(w_instr), .instr_opcode(w_opcode), .instr_pc(w_pc),
    .redirect_valid(w_redir), .redirect_target(w_target),
    .fetch_count(w_count), .dbg_state(w_dbg)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input bit wrap);
    int n = 0;
    while (!(wrap ? w_req : imem_req) && n < 20) begin
      tick();
      n++;
    end
    check(wrap ? "w_req_seen" : "req_seen", wrap ? w_req : imem_req, 1);
  endtask

  // Memory: answers each request mem_lat cycles later with addr ^ 0x33.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req) begin
        mem_a = imem_addr;
        repeat (mem_lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_a ^ 32'h0000_0033;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
      end
    end
  end

  // Monitor: every request and every accepted instruction must be expected.
  always @(negedge clk) begin
    if (rst_n && imem_req) begin
      if (exp_addr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_req: addr %h, nothing expected", imem_addr);
      end else begin
        check("imem_addr", imem_addr, exp_addr_q.pop_front());
      end
    end
    if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
      if (exp_instr_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_accept: pc %h instr %h", instr_pc, instr);
      end else begin
        mon_e = exp_instr_q.pop_front();
        check("instr_pc_word", {instr_pc, instr}, mon_e);
        check("instr_opcode", instr_opcode, mon_e[6:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    rst_w_n = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_ready = 1'b0; w_redir = 1'b0; w_target = '0;
    repeat (2) tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_count", fetch_count, 0);
    check("rst_state", dbg_state, 0);

    // Basic fetch: 0x0 returns 0x33 (R-type), then 0x4
    rst_n = 1'b1;
    exp_addr_q.push_back(32'h0);
    exp_instr_q.push_back({32'h0, 32'h0000_0033});
    exp_addr_q.push_back(32'h4);
    instr_ready = 1'b1;
    wait_req(0);
    tick();
    check("lat_wait_valid", instr_valid, 0);
    tick();
    check("lat_hold_valid", instr_valid, 1);
    check("first_opcode", instr_opcode, 7'b0110011);
    tick();
    check("next_req", imem_req, 1);
    check("count1", fetch_count, 1);

    // Backpressure on word at 0x4 (0x37)
    instr_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", instr_valid, 1);
      check("bp_instr", instr, 32'h0000_0037);
      check("bp_pc", instr_pc, 32'h4);
      check("bp_no_req", imem_req, 0);
      tick();
    end
    exp_instr_q.push_back({32'h4, 32'h0000_0037});
    exp_addr_q.push_back(32'h8);
    instr_ready = 1'b1;
    tick();
    check("count2", fetch_count, 2);

    // Redirect in HOLD beats ready; target 0x103 aligns to 0x100
    instr_ready = 1'b0;
    tick();
    tick();
    check("hold_before_redir", instr_valid, 1);
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h103;
    exp_addr_q.push_back(32'h100);
    tick();
    redirect_valid = 1'b0;
    check("redir_hold_count", fetch_count, 2);
    check("redir_hold_req", imem_req, 1);

    // Redirect in WAIT, response 3 cycles later must be dropped
    mem_lat = 4;
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    exp_addr_q.push_back(32'h200);
    tick();
    redirect_valid = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 3; i++) begin
      check("discard_valid", instr_valid, 0);
      tick();
    end
    wait_req(0);
    exp_instr_q.push_back({32'h200, 32'h0000_0233});
    exp_addr_q.push_back(32'h204);
    tick();
    tick();
    tick();

    // Redirect coincident with rvalid for 0x204
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h302;
    exp_addr_q.push_back(32'h300);
    tick();
    redirect_valid = 1'b0;
    check("coinc_valid", instr_valid, 0);
    check("coinc_req", imem_req, 1);
    exp_instr_q.push_back({32'h300, 32'h0000_0333});
    exp_addr_q.push_back(32'h304);
    tick();
    tick();
    tick();
    instr_ready = 1'b0;
    tick();
    tick();
    check("final_instr", instr, 32'h0000_0337);
    check("final_pc", instr_pc, 32'h304);
    check("final_count", fetch_count, 4);
    repeat (3) tick();
    check("addr_q_empty", exp_addr_q.size(), 0);
    check("instr_q_empty", exp_instr_q.size(), 0);

    // PC wrap on the top-of-memory instance
    rst_w_n = 1'b1;
    wait_req(1);
    check("w_first_addr", w_addr, 32'hFFFF_FFFC);
    tick();
    w_rvalid = 1'b1;
    w_rdata = 32'h0000_006F;
    tick();
    w_rvalid = 1'b0;
    check("w_valid", w_valid, 1);
    check("w_opcode", w_opcode, 7'b1101111);
    check("w_instr_pc", w_pc, 32'hFFFF_FFFC);
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    check("w_wrap_req", w_req, 1);
    check("w_wrap_addr", w_addr, 32'h0);
    check("w_count", w_count, 1);

    // Asynchronous reset while waiting on memory
    tick();
    check("w_in_wait", w_dbg, 2);
    #2;
    rst_w_n = 1'b0;
    #1;
    check("w_rst_req", w_req, 0);
    check("w_rst_valid", w_valid, 0);
    check("w_rst_count", w_count, 0);
    check("w_rst_state", w_dbg, 0);
    tick();
    rst_w_n = 1'b1;
    wait_req(1);
    check("w_restart_addr", w_addr, 32'hFFFF_FFFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
